// File: rtl/escalonador_rr_param.sv
// Round-robin process scheduler: PID table, programmable quantum and
// context-switch request/ack handshake towards the CPU/OS.
//
// Ports:
//   clock, reset                     system clock, synchronous active-high reset
//   novo_processo/novo_valido        insert a PID (accepted when novo_pronto)
//   novo_pronto                      table has a free slot
//   remover_valido/remover_pid       remove every valid slot holding that PID
//   quantum_wr/quantum_in            load a new quantum (0 stored as 1)
//   yield                            running process gives up its slice
//   troca_ack                        CPU has taken the context switch
//   processo_atual/processo_valido   selected PID and its qualifier
//   slot_atual                       table slot of the selected PID
//   troca_contexto                   switch request, held until acknowledged
//   num_processos/cheio              occupancy count and full flag
module escalonador_rr_param #(
    parameter int PID_W           = 32,
    parameter int MAX_PROC        = 10,
    parameter int QUANTUM_W       = 32,
    parameter int DEFAULT_QUANTUM = 20,
    localparam int SLOT_W = $clog2(MAX_PROC),
    localparam int CNT_W  = $clog2(MAX_PROC + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PID_W-1:0]     novo_processo,
    input  logic                 novo_valido,
    output logic                 novo_pronto,
    input  logic                 remover_valido,
    input  logic [PID_W-1:0]     remover_pid,
    input  logic                 quantum_wr,
    input  logic [QUANTUM_W-1:0] quantum_in,
    input  logic                 yield,
    input  logic                 troca_ack,
    output logic [PID_W-1:0]     processo_atual,
    output logic                 processo_valido,
    output logic [SLOT_W-1:0]    slot_atual,
    output logic                 troca_contexto,
    output logic [CNT_W-1:0]     num_processos,
    output logic                 cheio
);

    typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;

    state_t               state_q, state_d;
    logic [PID_W-1:0]     pid_q [MAX_PROC];
    logic [PID_W-1:0]     pid_d [MAX_PROC];
    logic [MAX_PROC-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic [QUANTUM_W-1:0] quantum_q, quantum_d;
    logic [QUANTUM_W-1:0] contador_q, contador_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;

    logic [MAX_PROC-1:0]  rm_hit, valid_rm;
    logic [CNT_W-1:0]     rm_cnt;
    logic                 ins_ok, any_left, cur_gone, expire;
    logic [SLOT_W-1:0]    ins_slot, nxt, first;

    // Lowest set bit of m (0 when m is empty).
    function automatic logic [SLOT_W-1:0] lowest(input logic [MAX_PROC-1:0] m);
        logic [SLOT_W-1:0] r;
        r = '0;
        for (int i = MAX_PROC - 1; i >= 0; i--) begin
            if (m[i]) r = SLOT_W'(i);
        end
        return r;
    endfunction

    // First set bit strictly after cur, wrapping; cur itself is the last candidate.
    function automatic logic [SLOT_W-1:0] next_slot(input logic [MAX_PROC-1:0] m,
                                                    input logic [SLOT_W-1:0]   cur);
        logic [SLOT_W-1:0] r;
        logic              found;
        int                idx;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= MAX_PROC; i++) begin
            idx = int'(cur) + i;
            if (idx >= MAX_PROC) idx = idx - MAX_PROC;
            if (!found && m[SLOT_W'(idx)]) begin
                found = 1'b1;
                r     = SLOT_W'(idx);
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        valid_d    = valid_q;
        num_d      = num_q;
        quantum_d  = quantum_q;
        contador_d = contador_q;
        slot_d     = slot_q;
        rm_hit     = '0;
        rm_cnt     = '0;

        for (int i = 0; i < MAX_PROC; i++) begin
            if (remover_valido && valid_q[i] && pid_q[i] == remover_pid) begin
                rm_hit[i] = 1'b1;
                rm_cnt    = rm_cnt + CNT_W'(1);
            end
        end

        // Scheduling sees the table after removal but before this cycle's
        // insert, so an insert can never preempt or redirect a selection.
        valid_rm = valid_q & ~rm_hit;
        ins_ok   = novo_valido && !cheio;
        ins_slot = lowest(~valid_q);
        valid_d  = valid_rm;
        if (ins_ok) begin
            valid_d[ins_slot] = 1'b1;
            pid_d[ins_slot]   = novo_processo;
        end
        num_d = num_q - rm_cnt + (ins_ok ? CNT_W'(1) : CNT_W'(0));

        if (quantum_wr) begin
            quantum_d = (quantum_in == '0) ? QUANTUM_W'(1) : quantum_in;
        end

        any_left = |valid_rm;
        cur_gone = rm_hit[slot_q];
        nxt      = next_slot(valid_rm, slot_q);
        first    = lowest(valid_rm);
        // >= so that a quantum lowered mid-slice expires immediately.
        expire   = contador_q >= (quantum_q - QUANTUM_W'(1));

        unique case (state_q)
            IDLE: begin
                if (any_left) begin
                    state_d = SWITCH;
                    slot_d  = first;
                end
            end
            SWITCH: begin
                if (cur_gone) begin
                    if (any_left) begin
                        slot_d = nxt;
                    end else begin
                        state_d = IDLE;
                        slot_d  = '0;
                    end
                end else if (troca_ack) begin
                    state_d    = RUN;
                    contador_d = '0;
                end
            end
            RUN: begin
                contador_d = contador_q + QUANTUM_W'(1);
                if (cur_gone) begin
                    if (any_left) begin
                        state_d = SWITCH;
                        slot_d  = nxt;
                    end else begin
                        state_d = IDLE;
                        slot_d  = '0;
                    end
                end else if (expire || yield) begin
                    if (nxt != slot_q) begin
                        state_d = SWITCH;
                        slot_d  = nxt;
                    end else begin
                        contador_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            num_q      <= '0;
            quantum_q  <= QUANTUM_W'(DEFAULT_QUANTUM);
            contador_q <= '0;
            slot_q     <= '0;
            for (int i = 0; i < MAX_PROC; i++) pid_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            num_q      <= num_d;
            quantum_q  <= quantum_d;
            contador_q <= contador_d;
            slot_q     <= slot_d;
            pid_q      <= pid_d;
        end
    end

    assign processo_valido = (state_q != IDLE);
    assign processo_atual  = processo_valido ? pid_q[slot_q] : '0;
    assign slot_atual      = slot_q;
    assign troca_contexto  = (state_q == SWITCH);
    assign num_processos   = num_q;
    assign cheio           = (num_q == CNT_W'(MAX_PROC));
    assign novo_pronto     = !cheio;

endmodule

// File: tb/tb_escalonador_rr_param.sv
// Directed bench for the round-robin scheduler: selected PIDs are queued
// as expectations when stimulus is driven and popped at each switch.
module tb_escalonador_rr_param;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] novo_processo;
    logic        novo_valido;
    logic        novo_pronto;
    logic        remover_valido;
    logic [31:0] remover_pid;
    logic        quantum_wr;
    logic [31:0] quantum_in;
    logic        yield;
    logic        troca_ack;
    logic [31:0] processo_atual;
    logic        processo_valido;
    logic [3:0]  slot_atual;
    logic        troca_contexto;
    logic [3:0]  num_processos;
    logic        cheio;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb [$];

    escalonador_rr_param dut (
        .clock           (clock),
        .reset           (reset),
        .novo_processo   (novo_processo),
        .novo_valido     (novo_valido),
        .novo_pronto     (novo_pronto),
        .remover_valido  (remover_valido),
        .remover_pid     (remover_pid),
        .quantum_wr      (quantum_wr),
        .quantum_in      (quantum_in),
        .yield           (yield),
        .troca_ack       (troca_ack),
        .processo_atual  (processo_atual),
        .processo_valido (processo_valido),
        .slot_atual      (slot_atual),
        .troca_contexto  (troca_contexto),
        .num_processos   (num_processos),
        .cheio           (cheio)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valido"}, 64'(processo_valido), 64'd0);
        chk({tag, "_atual"}, 64'(processo_atual), 64'd0);
        chk({tag, "_slot"}, 64'(slot_atual), 64'd0);
        chk({tag, "_troca"}, 64'(troca_contexto), 64'd0);
        chk({tag, "_num"}, 64'(num_processos), 64'd0);
        chk({tag, "_cheio"}, 64'(cheio), 64'd0);
        chk({tag, "_pronto"}, 64'(novo_pronto), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic ins(input logic [31:0] pid);
        novo_processo = pid;
        novo_valido   = 1'b1;
        @(negedge clock);
        novo_valido   = 1'b0;
    endtask

    task automatic ack();
        troca_ack = 1'b1;
        @(negedge clock);
        troca_ack = 1'b0;
    endtask

    task automatic rm(input logic [31:0] pid);
        remover_pid    = pid;
        remover_valido = 1'b1;
        @(negedge clock);
        remover_valido = 1'b0;
    endtask

    // Bounded wait for a switch request, then compare against the scoreboard.
    task automatic wait_sw(input string tag);
        int          n;
        logic [31:0] e;
        n = 0;
        while (troca_contexto !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_timeout"}, 64'(troca_contexto), 64'd1);
        e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        chk(tag, 64'(processo_atual), 64'(e));
    endtask

    // Cycles spent running after an ack until the next switch request.
    task automatic slice_len(output int n);
        n = 0;
        while (troca_contexto === 1'b0 && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin
        int n;
        int bad;
        reset          = 1'b1;
        novo_processo  = '0;
        novo_valido    = 1'b0;
        remover_valido = 1'b0;
        remover_pid    = '0;
        quantum_wr     = 1'b0;
        quantum_in     = '0;
        yield          = 1'b0;
        troca_ack      = 1'b0;
        repeat (2) @(negedge clock);
        chk_reset("rst");
        reset = 1'b0;

        ins(32'hA);
        ins(32'hB);
        chk("t1_troca", 64'(troca_contexto), 64'd1);
        chk("t1_sel", 64'(processo_atual), 64'hA);
        ins(32'hC);
        chk("t1_num", 64'(num_processos), 64'd3);

        sb.push_back(32'hA);
        sb.push_back(32'hB);
        sb.push_back(32'hC);
        sb.push_back(32'hA);
        for (int k = 0; k < 3; k++) begin
            wait_sw("t2_pid");
            ack();
            slice_len(n);
            chk("t2_slice", 64'(n), 64'd20);
        end
        wait_sw("t2_wrap");

        do_reset();
        for (int i = 0; i < 10; i++) ins(32'h100 + 32'(i));
        chk("t3_cheio", 64'(cheio), 64'd1);
        chk("t3_pronto", 64'(novo_pronto), 64'd0);
        chk("t3_num", 64'(num_processos), 64'd10);
        ins(32'h1FF);
        chk("t3_num11", 64'(num_processos), 64'd10);
        sb.push_back(32'h100);
        wait_sw("t3_sel");

        ack();
        repeat (3) @(negedge clock);
        sb.push_back(32'h101);
        rm(32'h100);
        chk("t4_imm", 64'(troca_contexto), 64'd1);
        chk("t4_slot", 64'(slot_atual), 64'd1);
        chk("t4_num", 64'(num_processos), 64'd9);
        wait_sw("t4_next");

        do_reset();
        ins(32'hD);
        sb.push_back(32'hD);
        wait_sw("t4_one");
        ack();
        rm(32'hD);
        chk("t4_idle_valido", 64'(processo_valido), 64'd0);
        chk("t4_idle_troca", 64'(troca_contexto), 64'd0);
        chk("t4_idle_num", 64'(num_processos), 64'd0);

        do_reset();
        ins(32'h1);
        ins(32'h2);
        sb.push_back(32'h1);
        wait_sw("t5_first");
        ack();
        repeat (3) @(negedge clock);
        chk("t5_pre", 64'(troca_contexto), 64'd0);
        yield = 1'b1;
        @(negedge clock);
        yield = 1'b0;
        chk("t5_imm", 64'(troca_contexto), 64'd1);
        sb.push_back(32'h2);
        wait_sw("t5_yield");
        remover_pid    = 32'h1;
        remover_valido = 1'b1;
        quantum_in     = '0;
        quantum_wr     = 1'b1;
        @(negedge clock);
        remover_valido = 1'b0;
        quantum_wr     = 1'b0;
        chk("t5_num", 64'(num_processos), 64'd1);
        chk("t5_keep", 64'(processo_atual), 64'h2);
        ack();
        bad = 0;
        repeat (10) begin
            if (troca_contexto !== 1'b0 || processo_valido !== 1'b1) bad++;
            @(negedge clock);
        end
        chk("t5_single", 64'(bad), 64'd0);

        do_reset();
        ins(32'h31);
        ins(32'h32);
        ins(32'h33);
        sb.push_back(32'h31);
        wait_sw("t6_first");
        remover_pid    = 32'h31;
        remover_valido = 1'b1;
        troca_ack      = 1'b1;
        @(negedge clock);
        remover_valido = 1'b0;
        troca_ack      = 1'b0;
        chk("t6_stay", 64'(troca_contexto), 64'd1);
        chk("t6_pid", 64'(processo_atual), 64'h32);
        chk("t6_slot", 64'(slot_atual), 64'd1);
        chk("t6_num", 64'(num_processos), 64'd2);
        ack();
        repeat (2) @(negedge clock);
        chk("t6_run", 64'(processo_valido), 64'd1);
        do_reset();
        chk_reset("t6_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
